// File: rtl/alu_pkg.sv
// Shared ALUOp codes, datapath width and op classification for the EX-stage ALU.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;
    localparam int unsigned ALUOP_W   = 5;

    typedef logic [ALUOP_W-1:0] aluop_t;

    localparam aluop_t ALU_AND   = 5'd0;
    localparam aluop_t ALU_OR    = 5'd1;
    localparam aluop_t ALU_ADD   = 5'd2;
    localparam aluop_t ALU_XOR   = 5'd3;
    localparam aluop_t ALU_SLL   = 5'd4;
    localparam aluop_t ALU_SRL   = 5'd5;
    localparam aluop_t ALU_SUB   = 5'd6;
    localparam aluop_t ALU_NOR   = 5'd7;
    localparam aluop_t ALU_ROTR  = 5'd9;
    localparam aluop_t ALU_SRA   = 5'd10;
    localparam aluop_t ALU_SGTZ  = 5'd11;
    localparam aluop_t ALU_SLT   = 5'd12;
    localparam aluop_t ALU_SLTU  = 5'd15;
    localparam aluop_t ALU_MOVC  = 5'd16;
    localparam aluop_t ALU_LUI   = 5'd17;
    localparam aluop_t ALU_SGEZ  = 5'd18;
    localparam aluop_t ALU_MULTU = 5'd26;
    localparam aluop_t ALU_MFLO  = 5'd27;
    localparam aluop_t ALU_MFHI  = 5'd28;
    localparam aluop_t ALU_MSUB  = 5'd29;
    localparam aluop_t ALU_MADD  = 5'd30;
    localparam aluop_t ALU_MUL   = 5'd31;

    function automatic logic is_mult_op(input aluop_t op);
        return (op == ALU_MULTU) || (op == ALU_MSUB) || (op == ALU_MADD) || (op == ALU_MUL);
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Issue/result bundle between the EX-stage control and the ALU execution unit.
interface alu_exec_unit_if import alu_pkg::*; #(
    parameter int unsigned WIDTH = ALU_WIDTH
);
    logic             In_Valid;
    aluop_t           ALUOp;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             MtHi;
    logic             MtLo;
    logic [WIDTH-1:0] Result;
    logic             Zero;
    logic             Busy;
    logic             Stall;
    logic             Done;

    modport master (
        output In_Valid, ALUOp, A, B, MtHi, MtLo,
        input  Result, Zero, Busy, Stall, Done
    );

    modport slave (
        input  In_Valid, ALUOp, A, B, MtHi, MtLo,
        output Result, Zero, Busy, Stall, Done
    );
endinterface

// File: rtl/iter_multiplier.sv
// Radix-2 shift-add multiplier on operand magnitudes; WIDTH run cycles, then a one-cycle done.
module iter_multiplier import alu_pkg::*; #(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               start_i,
    input  logic               signed_mode_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic                 neg_q, neg_d;
    logic [WIDTH:0]       step_sum;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            neg_q   <= neg_d;
        end
    end

    // acc holds {partial high, remaining multiplier bits}; each step adds and shifts right
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        neg_d    = neg_q;
        step_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        case (state_q)
            ST_RUN: begin
                acc_d = {step_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    mcand_d = magnitude(a_i, signed_mode_i);
                    acc_d   = {WIDTH'(0), magnitude(b_i, signed_mode_i)};
                    neg_d   = signed_mode_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    assign busy_o    = (state_q == ST_RUN);
    assign done_o    = (state_q == ST_DONE);
    assign product_o = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: single-cycle op mux plus HI/LO ownership and iterative multiply/accumulate.
module alu_exec_unit import alu_pkg::*; #(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic           Clk,
    input  logic           Reset,
    alu_exec_unit_if.slave bus
);
    localparam int unsigned SH_W = $clog2(WIDTH);

    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    aluop_t             mop_q, mop_d;
    logic               mul_start, mul_busy, mul_done, mul_out_sel, stall_c;
    logic [2*WIDTH-1:0] product, hilo_cur, hilo_ret, hilo_view, rot_src;
    logic [SH_W-1:0]    shamt;
    logic [WIDTH-1:0]   alu_res, result_c;
    logic               zero_on_b;

    assign mul_start = bus.In_Valid && !mul_busy && is_mult_op(bus.ALUOp);
    assign stall_c   = mul_busy && bus.In_Valid &&
                       ((bus.ALUOp >= ALU_MULTU) || bus.MtHi || bus.MtLo);

    iter_multiplier #(.WIDTH(WIDTH)) u_mult (
        .Clk           (Clk),
        .Reset         (Reset),
        .start_i       (mul_start),
        .signed_mode_i (bus.ALUOp != ALU_MULTU),
        .a_i           (bus.A),
        .b_i           (bus.B),
        .busy_o        (mul_busy),
        .done_o        (mul_done),
        .product_o     (product)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            hi_q  <= '0;
            lo_q  <= '0;
            mop_q <= '0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            mop_q <= mop_d;
        end
    end

    // Retiring multiply owns HI/LO that cycle; mfhi/mflo see the retiring value via hilo_view
    always_comb begin
        hilo_cur = {hi_q, lo_q};
        case (mop_q)
            ALU_MULTU: hilo_ret = product;
            ALU_MADD:  hilo_ret = hilo_cur + product;
            ALU_MSUB:  hilo_ret = hilo_cur - product;
            default:   hilo_ret = hilo_cur;
        endcase
        hilo_view = mul_done ? hilo_ret : hilo_cur;
        mop_d     = mul_start ? bus.ALUOp : mop_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (mul_done) begin
            {hi_d, lo_d} = hilo_ret;
        end else if (bus.In_Valid && !stall_c && !is_mult_op(bus.ALUOp)) begin
            if (bus.MtHi) hi_d = bus.A;
            if (bus.MtLo) lo_d = bus.A;
        end
    end

    assign shamt   = bus.A[SH_W-1:0];
    assign rot_src = {bus.B, bus.B} >> shamt;

    always_comb begin
        alu_res = '0;
        case (bus.ALUOp)
            ALU_AND:  alu_res = bus.A & bus.B;
            ALU_OR:   alu_res = bus.A | bus.B;
            ALU_ADD:  alu_res = bus.A + bus.B;
            ALU_XOR:  alu_res = bus.A ^ bus.B;
            ALU_SUB:  alu_res = bus.A - bus.B;
            ALU_NOR:  alu_res = ~(bus.A | bus.B);
            ALU_SLL:  alu_res = bus.B << shamt;
            ALU_SRL:  alu_res = bus.B >> shamt;
            ALU_ROTR: alu_res = rot_src[WIDTH-1:0];
            ALU_SRA:  alu_res = $unsigned($signed(bus.B) >>> shamt);
            ALU_SGTZ: alu_res = WIDTH'(!bus.A[WIDTH-1] && (bus.A != '0));
            ALU_SLT:  alu_res = WIDTH'($signed(bus.A) < $signed(bus.B));
            ALU_SLTU: alu_res = WIDTH'(bus.A < bus.B);
            ALU_SGEZ: alu_res = WIDTH'(!bus.A[WIDTH-1]);
            ALU_MOVC: alu_res = bus.A;
            ALU_LUI:  alu_res = bus.B << 16;
            ALU_MFLO: alu_res = hilo_view[WIDTH-1:0];
            ALU_MFHI: alu_res = hilo_view[2*WIDTH-1:WIDTH];
            default:  alu_res = '0;
        endcase
    end

    // A retiring mul drives Result for its Done cycle regardless of what is being issued
    assign mul_out_sel = mul_done && (mop_q == ALU_MUL);
    assign result_c    = mul_out_sel ? product[WIDTH-1:0] : (bus.In_Valid ? alu_res : '0);
    assign zero_on_b   = bus.In_Valid && !mul_out_sel &&
                         ((bus.ALUOp == ALU_MOVC) || (bus.ALUOp == ALU_MFLO) || (bus.ALUOp == ALU_MFHI));

    assign bus.Result = result_c;
    assign bus.Zero   = zero_on_b ? (bus.B == '0) : (result_c == '0);
    assign bus.Busy   = mul_busy;
    assign bus.Stall  = stall_c;
    assign bus.Done   = mul_done;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed + random ALU ops, multiply timing and HI/LO model.
module tb_alu_exec_unit;
    import alu_pkg::*;

    localparam int unsigned W = 32;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [31:0] m_hi, m_lo;

    alu_exec_unit_if #(.WIDTH(W)) bus();

    alu_exec_unit #(.WIDTH(W)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic mthi, input logic mtlo);
        bus.In_Valid = v;
        bus.ALUOp    = op;
        bus.A        = a;
        bus.B        = b;
        bus.MtHi     = mthi;
        bus.MtLo     = mtlo;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        drive(1'b1, 5'd28, 32'd0, 32'd1, 1'b0, 1'b0);
        hi = bus.Result;
        drive(1'b1, 5'd27, 32'd0, 32'd1, 1'b0, 1'b0);
        lo = bus.Result;
        idle();
    endtask

    // Reference ALU from the op definitions, using arithmetic and bit-at-a-time shifting
    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] hi,
                                            input logic [31:0] lo);
        int unsigned s;
        logic [31:0] r;
        s = a % 32;
        r = b;
        case (op)
            5'd0:  r = a & b;
            5'd1:  r = a | b;
            5'd2:  r = a + b;
            5'd3:  r = a ^ b;
            5'd6:  r = a - b;
            5'd7:  r = ~(a | b);
            5'd4:  repeat (s) r = r * 2;
            5'd5:  repeat (s) r = r / 2;
            5'd9:  repeat (s) r = {r[0], r[31:1]};
            5'd10: repeat (s) r = {r[31], r[31:1]};
            5'd11: r = ($signed(a) > 0) ? 32'd1 : 32'd0;
            5'd12: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd15: r = (a < b) ? 32'd1 : 32'd0;
            5'd18: r = ($signed(a) >= 0) ? 32'd1 : 32'd0;
            5'd16: r = a;
            5'd17: r = b * 32'd65536;
            5'd27: r = lo;
            5'd28: r = hi;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic ref_zero(input logic [4:0] op, input logic [31:0] b, input logic [31:0] res);
        if (op == 5'd16 || op == 5'd27 || op == 5'd28) return (b == 32'd0);
        return (res == 32'd0);
    endfunction

    function automatic logic [63:0] ref_prod(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        if (op == 5'd26) begin
            ua = {32'd0, a};
            ub = {32'd0, b};
            return ua * ub;
        end
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    // Applies a retiring multiply to the HI/LO model; returns the expected mul Result
    function automatic logic [31:0] model_mult(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p, acc;
        p   = ref_prod(op, a, b);
        acc = {m_hi, m_lo};
        case (op)
            5'd26: acc = p;
            5'd30: acc = acc + p;
            5'd29: acc = acc - p;
            default: ;
        endcase
        {m_hi, m_lo} = acc;
        return p[31:0];
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic run_mult(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int busy_cycles, output logic done_seen, output logic [31:0] res_done);
        drive(1'b1, op, a, b, 1'b0, 1'b0);
        step();
        idle();
        busy_cycles = 0;
        while (bus.Busy === 1'b1 && busy_cycles < 200) begin
            busy_cycles++;
            step();
        end
        done_seen = bus.Done;
        res_done  = bus.Result;
    endtask

    task automatic test_reset();
        logic [31:0] hi, lo;
        rst = 1'b1;
        idle();
        repeat (3) step();
        n_checks++;
        if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Stall !== 1'b0) begin
            $display("FAIL reset_flags: busy=%b done=%b stall=%b expected 0 0 0", bus.Busy, bus.Done, bus.Stall);
            n_fail++;
        end
        n_checks++;
        if (bus.Result !== 32'd0 || bus.Zero !== 1'b1) begin
            $display("FAIL reset_result: result=%h zero=%b expected 00000000 1", bus.Result, bus.Zero);
            n_fail++;
        end
        rst = 1'b0;
        step();
        m_hi = 32'd0;
        m_lo = 32'd0;
        read_hilo(hi, lo);
        n_checks++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            $display("FAIL reset_hilo: hi=%h lo=%h expected 0 0", hi, lo);
            n_fail++;
        end
    endtask

    task automatic test_alu_directed();
        logic [4:0]  ops [9] = '{5'd12, 5'd15, 5'd9, 5'd17, 5'd20, 5'd10, 5'd9, 5'd2, 5'd16};
        logic [31:0] av  [9] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd4, 32'd0, 32'd5, 32'd31, 32'd0, 32'hFFFFFFFF, 32'h0000ABCD};
        logic [31:0] bv  [9] = '{32'd1, 32'd1, 32'h0000000F, 32'h00001234, 32'd7, 32'h80000000, 32'h12345678, 32'd1, 32'd0};
        logic [31:0] ev  [9] = '{32'd1, 32'd0, 32'hF0000000, 32'h12340000, 32'd0, 32'hFFFFFFFF, 32'h12345678, 32'd0, 32'h0000ABCD};
        logic        ez  [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, ops[i], av[i], bv[i], 1'b0, 1'b0);
            n_checks++;
            if (bus.Result !== ev[i] || bus.Zero !== ez[i]) begin
                $display("FAIL alu_directed[%0d] op=%0d: result=%h zero=%b expected %h %b",
                         i, ops[i], bus.Result, bus.Zero, ev[i], ez[i]);
                n_fail++;
            end
            step();
        end
        idle();
    endtask

    task automatic test_alu_random();
        logic [4:0]  op;
        logic [31:0] a, b, exp_r;
        logic        mthi, mtlo;
        for (int i = 0; i < 80; i++) begin
            do op = 5'($urandom_range(0, 31)); while (is_mult_op(op));
            a    = pick_operand();
            b    = pick_operand();
            mthi = ($urandom_range(0, 3) == 0);
            mtlo = ($urandom_range(0, 3) == 0);
            drive(1'b1, op, a, b, mthi, mtlo);
            exp_r = ref_alu(op, a, b, m_hi, m_lo);
            n_checks++;
            if (bus.Result !== exp_r || bus.Zero !== ref_zero(op, b, exp_r) || bus.Stall !== 1'b0) begin
                $display("FAIL alu_random op=%0d a=%h b=%h: result=%h zero=%b stall=%b expected %h %b 0",
                         op, a, b, bus.Result, bus.Zero, bus.Stall, exp_r, ref_zero(op, b, exp_r));
                n_fail++;
            end
            step();
            if (mthi) m_hi = a;
            if (mtlo) m_lo = a;
        end
        idle();
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] hi, lo;
        int          dones;
        drive(1'b1, 5'd0, 32'h55, 32'd0, 1'b1, 1'b1);
        step();
        drive(1'b1, 5'd26, 32'hFFFFFFFF, 32'd3, 1'b0, 1'b0);
        step();
        idle();
        repeat (9) step();
        rst = 1'b1;
        step();
        n_checks++;
        if (bus.Busy !== 1'b0) begin
            $display("FAIL reset_mid_busy: busy=%b expected 0", bus.Busy);
            n_fail++;
        end
        rst = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.Done === 1'b1) dones++;
            step();
        end
        n_checks++;
        if (dones != 0) begin
            $display("FAIL reset_mid_done: done pulses=%0d expected 0", dones);
            n_fail++;
        end
        read_hilo(hi, lo);
        n_checks++;
        if (hi !== m_hi || lo !== m_lo) begin
            $display("FAIL reset_mid_hilo: hi=%h lo=%h expected %h %h", hi, lo, m_hi, m_lo);
            n_fail++;
        end
    endtask

    task automatic test_multu();
        int          bc;
        logic        dn;
        logic [31:0] res, hi, lo;
        run_mult(5'd26, 32'hFFFFFFFF, 32'd2, bc, dn, res);
        res = model_mult(5'd26, 32'hFFFFFFFF, 32'd2);
        n_checks++;
        if (bc != int'(W) || dn !== 1'b1 || bus.Busy !== 1'b0) begin
            $display("FAIL multu_timing: busy_cycles=%0d done=%b busy=%b expected %0d 1 0", bc, dn, bus.Busy, W);
            n_fail++;
        end
        step();
        n_checks++;
        if (bus.Done !== 1'b0) begin
            $display("FAIL multu_done_pulse: done=%b expected 0", bus.Done);
            n_fail++;
        end
        read_hilo(hi, lo);
        n_checks++;
        if (hi !== m_hi || lo !== m_lo || hi !== 32'd1 || lo !== 32'hFFFFFFFE) begin
            $display("FAIL multu_hilo: hi=%h lo=%h expected %h %h", hi, lo, m_hi, m_lo);
            n_fail++;
        end
    endtask

    task automatic test_madd_msub();
        int          bc;
        logic        dn;
        logic [31:0] res, hi, lo;
        drive(1'b1, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd0, 32'd5, 32'd0, 1'b0, 1'b1);
        step();
        m_hi = 32'd0;
        m_lo = 32'd5;
        run_mult(5'd30, 32'hFFFFFFFD, 32'd4, bc, dn, res);
        res = model_mult(5'd30, 32'hFFFFFFFD, 32'd4);
        step();
        read_hilo(hi, lo);
        n_checks++;
        if (hi !== m_hi || lo !== m_lo || dn !== 1'b1) begin
            $display("FAIL madd_hilo: hi=%h lo=%h done=%b expected %h %h 1", hi, lo, dn, m_hi, m_lo);
            n_fail++;
        end
        run_mult(5'd29, 32'hFFFFFFFD, 32'd4, bc, dn, res);
        res = model_mult(5'd29, 32'hFFFFFFFD, 32'd4);
        step();
        read_hilo(hi, lo);
        n_checks++;
        if (hi !== m_hi || lo !== m_lo || dn !== 1'b1) begin
            $display("FAIL msub_hilo: hi=%h lo=%h done=%b expected %h %h 1", hi, lo, dn, m_hi, m_lo);
            n_fail++;
        end
    endtask

    task automatic test_stall();
        logic [31:0] a, b, a2, b2, res;
        int          stalled;
        a  = $urandom();
        b  = $urandom();
        a2 = $urandom();
        b2 = $urandom();
        drive(1'b1, 5'd26, a, b, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd2, a2, b2, 1'b0, 1'b0);
        n_checks++;
        if (bus.Stall !== 1'b0 || bus.Result !== a2 + b2 || bus.Busy !== 1'b1) begin
            $display("FAIL stall_add: stall=%b result=%h busy=%b expected 0 %h 1", bus.Stall, bus.Result, bus.Busy, a2 + b2);
            n_fail++;
        end
        step();
        drive(1'b1, 5'd0, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b1);
        n_checks++;
        if (bus.Stall !== 1'b1) begin
            $display("FAIL stall_mtlo: stall=%b expected 1", bus.Stall);
            n_fail++;
        end
        step();
        drive(1'b1, 5'd27, 32'd0, 32'd1, 1'b0, 1'b0);
        stalled = 0;
        while (bus.Busy === 1'b1 && stalled < 100) begin
            n_checks++;
            if (bus.Stall !== 1'b1) begin
                $display("FAIL stall_mflo cycle %0d: stall=%b expected 1", stalled, bus.Stall);
                n_fail++;
            end
            stalled++;
            step();
        end
        res = model_mult(5'd26, a, b);
        n_checks++;
        if (stalled != int'(W) - 2 || bus.Done !== 1'b1 || bus.Stall !== 1'b0 || bus.Result !== m_lo) begin
            $display("FAIL stall_release: stalled=%0d done=%b stall=%b result=%h expected %0d 1 0 %h",
                     stalled, bus.Done, bus.Stall, bus.Result, W - 2, m_lo);
            n_fail++;
        end
        idle();
        step();
    endtask

    task automatic test_mul_back_to_back();
        int          bc, cyc;
        logic        dn;
        logic [31:0] res, exp_r, a2, b2, hi, lo, hi0, lo0;
        hi0 = m_hi;
        lo0 = m_lo;
        run_mult(5'd31, 32'hFFFFFFF9, 32'd6, bc, dn, res);
        exp_r = model_mult(5'd31, 32'hFFFFFFF9, 32'd6);
        n_checks++;
        if (res !== exp_r || res !== 32'hFFFFFFD6 || dn !== 1'b1) begin
            $display("FAIL mul_result: result=%h done=%b expected %h 1", res, dn, exp_r);
            n_fail++;
        end
        a2 = pick_operand();
        b2 = pick_operand();
        drive(1'b1, 5'd31, a2, b2, 1'b0, 1'b0);
        step();
        idle();
        cyc = 1;
        while (bus.Done !== 1'b1 && cyc < 200) begin
            step();
            cyc++;
        end
        exp_r = model_mult(5'd31, a2, b2);
        n_checks++;
        if (cyc != int'(W) + 1 || bus.Result !== exp_r) begin
            $display("FAIL mul_b2b: retire_cycles=%0d result=%h expected %0d %h", cyc, bus.Result, W + 1, exp_r);
            n_fail++;
        end
        step();
        read_hilo(hi, lo);
        n_checks++;
        if (hi !== hi0 || lo !== lo0) begin
            $display("FAIL mul_hilo_kept: hi=%h lo=%h expected %h %h", hi, lo, hi0, lo0);
            n_fail++;
        end
    endtask

    task automatic test_random_mult();
        logic [4:0]  mops [4] = '{5'd26, 5'd29, 5'd30, 5'd31};
        logic [4:0]  op;
        logic [31:0] a, b, res, exp_r, hi, lo;
        int          bc;
        logic        dn;
        for (int i = 0; i < 8; i++) begin
            op = mops[$urandom_range(0, 3)];
            a  = pick_operand();
            b  = pick_operand();
            run_mult(op, a, b, bc, dn, res);
            exp_r = model_mult(op, a, b);
            n_checks++;
            if (bc != int'(W) || dn !== 1'b1 || (op == 5'd31 && res !== exp_r)) begin
                $display("FAIL rmult op=%0d a=%h b=%h: busy=%0d done=%b result=%h expected %0d 1 %h",
                         op, a, b, bc, dn, res, W, exp_r);
                n_fail++;
            end
            step();
            read_hilo(hi, lo);
            n_checks++;
            if (hi !== m_hi || lo !== m_lo) begin
                $display("FAIL rmult_hilo op=%0d a=%h b=%h: hi=%h lo=%h expected %h %h",
                         op, a, b, hi, lo, m_hi, m_lo);
                n_fail++;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_hi     = 32'd0;
        m_lo     = 32'd0;
        rst      = 1'b1;
        test_reset();
        test_alu_directed();
        test_alu_random();
        test_reset_mid_op();
        test_multu();
        test_madd_msub();
        test_stall();
        test_mul_back_to_back();
        test_random_mult();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
